// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and counter sizing for the serial-in/parallel-out receiver.
package sipo_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// sipo_out_reg: output holding register with valid/ready handshake, overwrite and sticky overrun.
module sipo_out_reg #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [Width-1:0] wdata,
    input  logic             ready,
    input  logic             clear_ovr,
    output logic [Width-1:0] data,
    output logic             valid,
    output logic             done,
    output logic             overrun
);

    logic held;

    // A word still waiting after this edge means a fresh write would clobber it.
    assign held = valid & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= wr;
            valid   <= wr | held;
            overrun <= (wr & held) | (overrun & ~clear_ovr);
            if (wr)
                data <= wdata;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects Width MSB-first serial bits into a word and presents it on a valid/ready register.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Serial_in,
    input  logic             Serial_valid,
    input  logic             Start,
    output logic [Width-1:0] Data_out,
    output logic             Data_valid,
    input  logic             Data_ready,
    output logic             Done,
    output logic             Busy,
    output logic             Overrun,
    input  logic             Clear_ovr
);

    localparam int CNT_W = cnt_w(Width);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Width - 1);

    state_t           state, state_nxt;
    logic [Width-1:0] shift;
    logic [CNT_W-1:0] cnt;
    logic             restart, complete, frame_done;

    assign restart = Serial_valid & Start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = restart ? SHIFT : complete ? IDLE : state;
    end

    always_comb begin
        Busy     = (state == SHIFT);
        complete = (state == SHIFT) & Serial_valid & ~Start & (cnt == LAST);
    end

    // frame_done delays completion one edge so the full word is read from shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= complete;
            if (restart || (state == SHIFT && Serial_valid)) begin
                shift <= {shift[Width-2:0], Serial_in};
                cnt   <= restart ? CNT_W'(1) : complete ? '0 : cnt + 1'b1;
            end
        end
    end

    sipo_out_reg #(.Width(Width)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (frame_done),
        .wdata     (shift),
        .ready     (Data_ready),
        .clear_ovr (Clear_ovr),
        .data      (Data_out),
        .valid     (Data_valid),
        .done      (Done),
        .overrun   (Overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench for the serial-in/parallel-out receiver.
module tb_sipo_deserializer;

    logic        clk, rst_n;
    logic        Serial_in, Serial_valid, Start, Data_ready, Clear_ovr;
    logic [15:0] Data_out;
    logic        Data_valid, Done, Busy, Overrun;

    int n_chk, n_fail;
    int done_cnt, busy_cnt, valid_cnt;
    logic [15:0] exp_q[$];

    sipo_deserializer #(.Width(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Serial_in    (Serial_in),
        .Serial_valid (Serial_valid),
        .Start        (Start),
        .Data_out     (Data_out),
        .Data_valid   (Data_valid),
        .Data_ready   (Data_ready),
        .Done         (Done),
        .Busy         (Busy),
        .Overrun      (Overrun),
        .Clear_ovr    (Clear_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] word, input bit gap);
        for (int i = 15; i >= 0; i--) begin
            Serial_in    = word[i];
            Start        = (i == 15);
            Serial_valid = 1'b1;
            if (i == 0)
                exp_q.push_back(word);
            tick();
            if (gap) begin
                Serial_valid = 1'b0;
                Start        = 1'b0;
                tick();
            end
        end
        Serial_valid = 1'b0;
        Start        = 1'b0;
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            Serial_in    = 1'b1;
            Start        = (i == 0);
            Serial_valid = 1'b1;
            tick();
        end
        Serial_valid = 1'b0;
        Start        = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (Busy) busy_cnt++;
            if (Data_valid) valid_cnt++;
            if (Done) begin
                done_cnt++;
                if (exp_q.size() == 0)
                    check("spurious_done", Done, 1'b0);
                else
                    check("word", Data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        int d0;
        n_chk = 0; n_fail = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        rst_n = 1'b0; Serial_in = 1'b0; Serial_valid = 1'b0; Start = 1'b0;
        Data_ready = 1'b1; Clear_ovr = 1'b0;
        #1;
        check("rst_data", Data_out, 16'h0);
        check("rst_valid", Data_valid, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_ovr", Overrun, 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // Continuous frame, exact latency and pulse widths.
        busy_cnt = 0; valid_cnt = 0; d0 = done_cnt;
        send_frame(16'hA5C3, 1'b0);
        check("lat_done_early", Done, 1'b0);
        check("lat_valid_early", Data_valid, 1'b0);
        tick();
        check("lat_done", Done, 1'b1);
        check("lat_data", Data_out, 16'hA5C3);
        check("lat_valid", Data_valid, 1'b1);
        tick();
        check("done_pulse", Done, 1'b0);
        check("valid_drop", Data_valid, 1'b0);
        tick();
        check("busy_cycles", busy_cnt, 15);
        check("valid_cycles", valid_cnt, 1);
        check("done_once_a", done_cnt - d0, 1);

        // Gapped stream.
        d0 = done_cnt;
        send_frame(16'hA5C3, 1'b1);
        repeat (3) tick();
        check("gap_data", Data_out, 16'hA5C3);
        check("gap_done_once", done_cnt - d0, 1);

        // Mid-frame restart.
        d0 = done_cnt;
        send_partial(8);
        send_frame(16'h1234, 1'b0);
        repeat (3) tick();
        check("abort_data", Data_out, 16'h1234);
        check("abort_done_once", done_cnt - d0, 1);

        // Back-to-back frames under back-pressure.
        Data_ready = 1'b0;
        send_frame(16'h0001, 1'b0);
        send_frame(16'h8000, 1'b0);
        repeat (3) tick();
        check("ovr_data", Data_out, 16'h8000);
        check("ovr_valid", Data_valid, 1'b1);
        check("ovr_set", Overrun, 1'b1);
        Clear_ovr = 1'b1;
        tick();
        Clear_ovr = 1'b0;
        check("ovr_clear", Overrun, 1'b0);
        Data_ready = 1'b1;
        tick();
        check("drain_valid", Data_valid, 1'b0);

        // New word lands on the handshake edge.
        Data_ready = 1'b0;
        send_frame(16'h1111, 1'b0);
        repeat (2) tick();
        check("hs_hold_data", Data_out, 16'h1111);
        send_frame(16'hBEEF, 1'b0);
        Data_ready = 1'b1;
        tick();
        Data_ready = 1'b0;
        check("hs_valid", Data_valid, 1'b1);
        check("hs_data", Data_out, 16'hBEEF);
        check("hs_no_ovr", Overrun, 1'b0);
        Data_ready = 1'b1;
        tick();

        // Asynchronous reset mid-frame.
        Data_ready = 1'b0;
        send_frame(16'h0F0F, 1'b0);
        send_partial(7);
        check("pre_rst_valid", Data_valid, 1'b1);
        check("pre_rst_busy", Busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", Data_out, 16'h0);
        check("arst_valid", Data_valid, 1'b0);
        check("arst_busy", Busy, 1'b0);
        check("arst_done", Done, 1'b0);
        #3 rst_n = 1'b1;
        Data_ready = 1'b1;
        tick();
        d0 = done_cnt;
        send_frame(16'h5A5A, 1'b0);
        repeat (3) tick();
        check("post_rst_data", Data_out, 16'h5A5A);
        check("post_rst_done", done_cnt - d0, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver, the inverse of the team's parallel-to-serial shifter.
- Collects Width MSB-first bits from a 1-bit serial stream into a parallel word.
- Presents each completed word on a valid/ready output register; the downstream consumer is the overlapping sequence detector datapath.
- Handles frame start, mid-frame restart, back-pressure and overrun explicitly.

Parameters:
- Width, 16: bits per frame and Data_out width; legal range 2..64.
- CNT_W, $clog2(Width+1): bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Serial_in  input  1  serial data bit, sampled only when Serial_valid=1
- Serial_valid  input  1  qualifies Serial_in this cycle
- Start  input  1  marks the current valid bit as bit 0 (MSB) of a new frame; ignored when Serial_valid=0
- Data_out  output  Width  last completed word; first received bit lands at Data_out[Width-1]
- Data_valid  output  1  Data_out holds an unconsumed word
- Data_ready  input  1  consumer accepts the word when Data_valid & Data_ready
- Done  output  1  one-cycle pulse on the cycle after the last bit of a frame is sampled
- Busy  output  1  high while a frame is partially received
- Overrun  output  1  sticky; set when a word completes while the output register is still full
- Clear_ovr  input  1  synchronous clear of Overrun

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift reg=0, count=0, Data_out=0, Data_valid=0, Done=0, Busy=0, Overrun=0.
- State IDLE:
  - Serial_valid & Start: shift reg <= {.., Serial_in}, count=1, go to SHIFT.
  - Any other valid bit without Start is discarded.
- State SHIFT:
  - Each Serial_valid cycle: shift reg <= {shift[Width-2:0], Serial_in}, count+1.
  - Serial_valid=0: hold; gaps of any length are allowed.
  - Start & Serial_valid in SHIFT: abort the partial frame and restart with this bit as the new bit 0 (count=1). No Done, no word emitted.
  - When the Width-th bit is sampled (count==Width-1 & Serial_valid & ~Start), the frame completes: return to IDLE.
- Frame completion, on the following cycle:
  - Done=1 for exactly one cycle.
  - Completed word written to Data_out; Data_valid=1.
  - Latency: last bit sampled at edge N; Data_out/Data_valid/Done visible after edge N+1.
- Back-back frames: Start may accompany the bit immediately after the last bit of the previous frame; zero idle cycles are supported.
- Output handshake:
  - Data_valid stays high and Data_out stays stable until Data_valid & Data_ready.
  - On that handshake Data_valid drops the next cycle unless a new word completes in the same cycle.
  - Word completes in the same cycle as the handshake: Data_out takes the new word, Data_valid stays 1, no overrun.
  - Word completes while Data_valid=1 & Data_ready=0: the new word overwrites Data_out, Data_valid stays 1, Overrun <= 1.
- Overrun:
  - Cleared only by Clear_ovr or reset.
  - If a set and Clear_ovr coincide in the same cycle, set wins.
- Busy = (state==SHIFT).
- Counter: CNT_W bits, never exceeds Width-1 in SHIFT; no wrap-around.
- Reset mid-frame: partial frame lost, outputs return to reset values immediately (asynchronous).

Decomposition:
- Package sipo_pkg holds:
  - state enum {IDLE, SHIFT};
  - function cnt_w(width) returning $clog2(width+1).
- One sub-module, sipo_out_reg: the output holding register with valid/ready, overwrite and overrun logic (about 50 lines).
- Shift register, counter and FSM stay in the top module.

Test Plan:
- Width=16, send 0xA5C3 MSB-first with Start on bit 0, Serial_valid continuous, Data_ready=1 -> Done pulse 1 cycle after bit 15, Data_out=0xA5C3, Data_valid high for 1 cycle, Busy high for 15 cycles.
- Same word with Serial_valid toggling 1/0 (32 cycles) -> Data_out=0xA5C3; Done occurs exactly once.
- Send 8 bits of 0xFF.., then Start with frame 0x1234 -> Data_out=0x1234, only one Done, no word for the aborted frame.
- Two back-to-back frames 0x0001, 0x8000 with Data_ready=0 -> Data_out=0x8000, Overrun=1; Clear_ovr pulse -> Overrun=0.
- Frame 0xBEEF completes in the same cycle as the handshake for 0x1111 -> Data_valid stays 1, Data_out=0xBEEF, Overrun=0.
- rst_n low at bit 7 of a frame -> all outputs 0 asynchronously; the next full frame 0x5A5A is received correctly.
